// File: rtl/byte_bus_arbiter.sv
// byte_bus_arbiter
// Shares one byte-wide synchronous memory between the instruction-fetch and
// load/store requesters. Each accepted request is split into little-endian
// byte beats; read bytes are assembled into a 32-bit word. All outputs are
// registered: the next-state logic computes the values they take in the
// following cycle.
module byte_bus_arbiter #(
  parameter int MEM_RD_LAT    = 1,
  parameter int DATA_PRIORITY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_oe,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // WAIT cycles remaining after the first one of a read beat
  localparam logic [1:0] WAIT_INIT = 2'(MEM_RD_LAT - 1);
  localparam logic       DATA_WINS = (DATA_PRIORITY != 0);

  // Sign- or zero-extend an assembled load word according to its beat count
  function automatic logic [31:0] extend_load(input logic [31:0] w,
                                              input logic [1:0]  last,
                                              input logic        uns);
    logic [31:0] r;
    case (last)
      2'd0:    r = uns ? {24'd0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
      2'd1:    r = uns ? {16'd0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  state_e      state_q, state_d;
  logic        rr_q, rr_d;          // 1: data wins the next contested tie
  logic        fetch_q, fetch_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic [1:0]  last_q, last_d;      // index of the final beat (0, 1 or 3)
  logic [1:0]  beat_q, beat_d;
  logic [1:0]  wcnt_q, wcnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic        if_gnt_q, if_gnt_d;
  logic        d_gnt_q, d_gnt_d;
  logic        if_valid_q, if_valid_d;
  logic        d_valid_q, d_valid_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_oe_q, mem_oe_d;
  logic        mem_we_q, mem_we_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        busy_q, busy_d;

  logic        pick_data_s;
  logic [1:0]  next_beat_s;
  logic [31:0] beat_addr_s;
  logic [31:0] word_s;

  // Next-state, beat sequencing, arbitration and next output values
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    fetch_d     = fetch_q;
    we_d        = we_q;
    uns_d       = uns_q;
    last_d      = last_q;
    beat_d      = beat_q;
    wcnt_d      = wcnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_oe_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    pick_data_s = 1'b0;
    next_beat_s = beat_q + 2'd1;
    beat_addr_s = addr_q + {30'd0, next_beat_s};
    word_s      = buf_q;
    word_s[{beat_q, 3'b000} +: 8] = mem_rdata;

    case (state_q)
      S_IDLE: begin
        if (if_req && d_req) begin
          pick_data_s = DATA_WINS ? 1'b1 : rr_q;
          rr_d        = DATA_WINS ? rr_q : ~rr_q;
        end else begin
          pick_data_s = d_req;
        end
        if (pick_data_s) begin
          state_d     = S_ISSUE;
          fetch_d     = 1'b0;
          we_d        = d_we;
          uns_d       = d_unsigned;
          addr_d      = d_addr;
          wdata_d     = d_wdata;
          beat_d      = 2'd0;
          buf_d       = 32'd0;
          d_gnt_d     = 1'b1;
          mem_addr_d  = d_addr;
          mem_oe_d    = ~d_we;
          mem_we_d    = d_we;
          mem_wdata_d = d_we ? d_wdata[7:0] : mem_wdata_q;
          case (d_size)
            2'b00:   last_d = 2'd0;
            2'b01:   last_d = 2'd1;
            default: last_d = 2'd3;
          endcase
        end else if (if_req) begin
          state_d    = S_ISSUE;
          fetch_d    = 1'b1;
          we_d       = 1'b0;
          uns_d      = 1'b0;
          addr_d     = if_addr;
          last_d     = 2'd3;
          beat_d     = 2'd0;
          buf_d      = 32'd0;
          if_gnt_d   = 1'b1;
          mem_addr_d = if_addr;
          mem_oe_d   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (!we_q) begin
          state_d  = S_WAIT;
          wcnt_d   = WAIT_INIT;
          mem_oe_d = 1'b1;
        end else if (beat_q == last_q) begin
          state_d   = S_RESP;
          d_valid_d = 1'b1;
        end else begin
          beat_d      = next_beat_s;
          mem_addr_d  = beat_addr_s;
          mem_we_d    = 1'b1;
          mem_wdata_d = wdata_q[{next_beat_s, 3'b000} +: 8];
        end
      end
      S_WAIT: begin
        if (wcnt_q != 2'd0) begin
          wcnt_d   = wcnt_q - 2'd1;
          mem_oe_d = 1'b1;
        end else begin
          buf_d = word_s;
          if (beat_q != last_q) begin
            state_d    = S_ISSUE;
            beat_d     = next_beat_s;
            mem_addr_d = beat_addr_s;
            mem_oe_d   = 1'b1;
          end else if (fetch_q) begin
            state_d    = S_RESP;
            if_valid_d = 1'b1;
            if_rdata_d = word_s;
          end else begin
            state_d   = S_RESP;
            d_valid_d = 1'b1;
            d_rdata_d = extend_load(word_s, last_q, uns_q);
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, transaction context and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b0;
      fetch_q     <= 1'b0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      last_q      <= 2'd0;
      beat_q      <= 2'd0;
      wcnt_q      <= 2'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      buf_q       <= 32'd0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      if_rdata_q  <= 32'd0;
      d_rdata_q   <= 32'd0;
      mem_addr_q  <= 32'd0;
      mem_oe_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 8'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      fetch_q     <= fetch_d;
      we_q        <= we_d;
      uns_q       <= uns_d;
      last_q      <= last_d;
      beat_q      <= beat_d;
      wcnt_q      <= wcnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_oe_q    <= mem_oe_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_oe    = mem_oe_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule
